// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: NOP encoding, RV64 major
// opcodes, fetch FSM state encoding and small address helpers.
package instruction_fetch_unit_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned ILEN   = 32;
    localparam int unsigned CNT_W  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2
    } state_e;

    // Redirect targets may carry low bits; instructions are always word aligned.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

    function automatic logic [XLEN-1:0] next_seq_pc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if_id_register.sv
// IF/ID pipeline register: holds on stall, loads a fetched word, otherwise
// presents a NOP bubble while keeping the last PC.
module if_id_register
    import instruction_fetch_unit_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            hold_i,
    input  logic            load_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [ILEN-1:0] instr_i,
    output logic [XLEN-1:0] pc_o,
    output logic [ILEN-1:0] instr_o,
    output logic [6:0]      opcode_o,
    output logic            valid_o
);

    logic [XLEN-1:0] pc_q;
    logic [ILEN-1:0] instr_q;
    logic            valid_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else if (hold_i) begin
            pc_q    <= pc_q;
            instr_q <= instr_q;
            valid_q <= valid_q;
        end else if (load_i) begin
            pc_q    <= pc_i;
            instr_q <= instr_i;
            valid_q <= 1'b1;
        end else begin
            pc_q    <= pc_q;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end
    end

    assign pc_o     = pc_q;
    assign instr_o  = instr_q;
    assign opcode_o = instr_q[6:0];
    assign valid_o  = valid_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: PC, fetch FSM and delivered-instruction counter,
// feeding the IF/ID register. Redirect beats stall beats memory ready.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [XLEN-1:0]  branch_target,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic [ILEN-1:0]  imem_rdata,
    input  logic             imem_ready,
    output logic [XLEN-1:0]  if_id_pc,
    output logic [ILEN-1:0]  if_id_instr,
    output logic [6:0]       if_id_opcode,
    output logic             if_id_valid,
    output logic [CNT_W-1:0] fetch_count
);

    state_e           state_q;
    logic             imem_req_q;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] fetch_count_q, fetch_count_d;
    logic             fetch_fire;
    logic             ifid_hold;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            imem_req_q <= 1'b0;
        end else begin
            imem_req_q <= 1'b1;
            case (state_q)
                IDLE: state_q <= RUN;
                RUN: begin
                    if (!branch_taken && !imem_ready) state_q <= WAIT;
                end
                WAIT: begin
                    if (imem_ready || branch_taken) state_q <= RUN;
                end
                default: begin
                    state_q    <= IDLE;
                    imem_req_q <= 1'b0;
                end
            endcase
        end
    end

    // A returned word is only accepted when neither redirect nor stall wins.
    assign fetch_fire = imem_req_q && imem_ready && !stall && !branch_taken;
    assign ifid_hold  = stall && !branch_taken;

    always_comb begin
        pc_d          = pc_q;
        fetch_count_d = fetch_count_q;
        if (branch_taken) begin
            pc_d = word_align(branch_target);
        end else if (fetch_fire) begin
            pc_d          = next_seq_pc(pc_q);
            fetch_count_d = fetch_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= '0;
            fetch_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    if_id_register u_if_id (
        .clk_i    (clk),
        .rst_i    (reset),
        .hold_i   (ifid_hold),
        .load_i   (fetch_fire),
        .pc_i     (pc_q),
        .instr_i  (imem_rdata),
        .pc_o     (if_id_pc),
        .instr_o  (if_id_instr),
        .opcode_o (if_id_opcode),
        .valid_o  (if_id_valid)
    );

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a small combinational memory.
module tb_instruction_fetch_unit;
    import instruction_fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [63:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic [6:0]  if_id_opcode;
    logic        if_id_valid;
    logic [31:0] fetch_count;

    int chk_total = 0;
    int chk_pass  = 0;

    instruction_fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_ready    (imem_ready),
        .if_id_pc      (if_id_pc),
        .if_id_instr   (if_id_instr),
        .if_id_opcode  (if_id_opcode),
        .if_id_valid   (if_id_valid),
        .fetch_count   (fetch_count)
    );

    always #5 clk = ~clk;

    // Memory: word 0 is addi x1,x0,10; other words are {addr[24:0], 7'b0110011}.
    always_comb begin
        if (imem_addr == 64'd0) imem_rdata = 32'h00A0_0093;
        else                    imem_rdata = {imem_addr[24:0], 7'b0110011};
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0;
        branch_target = 64'd0; imem_ready = 1'b1;
        step(); step();
        chk_total++; if (imem_req !== 1'b0) $display("FAIL rst_req got=%0h exp=0", imem_req); else chk_pass++;
        chk_total++; if (imem_addr !== 64'd0) $display("FAIL rst_addr got=%0h exp=0", imem_addr); else chk_pass++;
        chk_total++; if (if_id_instr !== 32'h0000_0013) $display("FAIL rst_instr got=%0h exp=13", if_id_instr); else chk_pass++;
        chk_total++; if (if_id_opcode !== 7'b0010011) $display("FAIL rst_opcode got=%0b exp=0010011", if_id_opcode); else chk_pass++;
        chk_total++; if (if_id_valid !== 1'b0) $display("FAIL rst_valid got=%0h exp=0", if_id_valid); else chk_pass++;
        chk_total++; if (if_id_pc !== 64'd0) $display("FAIL rst_pc got=%0h exp=0", if_id_pc); else chk_pass++;
        chk_total++; if (fetch_count !== 32'd0) $display("FAIL rst_count got=%0d exp=0", fetch_count); else chk_pass++;
        reset = 1'b0;
        step();
        chk_total++; if (imem_req !== 1'b1) $display("FAIL idle_exit_req got=%0h exp=1", imem_req); else chk_pass++;
        chk_total++; if (if_id_valid !== 1'b0) $display("FAIL idle_valid got=%0h exp=0", if_id_valid); else chk_pass++;
        chk_total++; if (fetch_count !== 32'd0) $display("FAIL idle_count got=%0d exp=0", fetch_count); else chk_pass++;
    endtask

    task automatic test_first_fetch();
        step();
        chk_total++; if (if_id_pc !== 64'd0) $display("FAIL first_pc got=%0h exp=0", if_id_pc); else chk_pass++;
        chk_total++; if (if_id_instr !== 32'h00A0_0093) $display("FAIL first_instr got=%0h exp=a00093", if_id_instr); else chk_pass++;
        chk_total++; if (if_id_opcode !== 7'b0010011) $display("FAIL first_opcode got=%0b exp=0010011", if_id_opcode); else chk_pass++;
        chk_total++; if (if_id_valid !== 1'b1) $display("FAIL first_valid got=%0h exp=1", if_id_valid); else chk_pass++;
        chk_total++; if (imem_addr !== 64'd4) $display("FAIL first_next_pc got=%0h exp=4", imem_addr); else chk_pass++;
        chk_total++; if (fetch_count !== 32'd1) $display("FAIL first_count got=%0d exp=1", fetch_count); else chk_pass++;
    endtask

    task automatic test_back_to_back();
        step();
        chk_total++; if (if_id_pc !== 64'd4) $display("FAIL b2b_pc got=%0h exp=4", if_id_pc); else chk_pass++;
        chk_total++; if (if_id_instr !== 32'h0000_0233) $display("FAIL b2b_instr got=%0h exp=233", if_id_instr); else chk_pass++;
        chk_total++; if (if_id_opcode !== 7'b0110011) $display("FAIL b2b_opcode got=%0b exp=0110011", if_id_opcode); else chk_pass++;
        chk_total++; if (imem_addr !== 64'd8) $display("FAIL b2b_next_pc got=%0h exp=8", imem_addr); else chk_pass++;
        chk_total++; if (fetch_count !== 32'd2) $display("FAIL b2b_count got=%0d exp=2", fetch_count); else chk_pass++;
    endtask

    task automatic test_wait_states();
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_total++; if (if_id_valid !== 1'b0) $display("FAIL wait%0d_valid got=%0h exp=0", i, if_id_valid); else chk_pass++;
            chk_total++; if (if_id_instr !== 32'h0000_0013) $display("FAIL wait%0d_instr got=%0h exp=13", i, if_id_instr); else chk_pass++;
            chk_total++; if (if_id_pc !== 64'd4) $display("FAIL wait%0d_ifid_pc got=%0h exp=4", i, if_id_pc); else chk_pass++;
            chk_total++; if (imem_addr !== 64'd8) $display("FAIL wait%0d_pc got=%0h exp=8", i, imem_addr); else chk_pass++;
            chk_total++; if (dut.state_q !== WAIT) $display("FAIL wait%0d_state got=%0d exp=%0d", i, dut.state_q, WAIT); else chk_pass++;
            chk_total++; if (imem_req !== 1'b1) $display("FAIL wait%0d_req got=%0h exp=1", i, imem_req); else chk_pass++;
        end
        chk_total++; if (fetch_count !== 32'd2) $display("FAIL wait_count got=%0d exp=2", fetch_count); else chk_pass++;
        imem_ready = 1'b1;
        step();
        chk_total++; if (if_id_pc !== 64'd8) $display("FAIL wait_done_pc got=%0h exp=8", if_id_pc); else chk_pass++;
        chk_total++; if (if_id_instr !== 32'h0000_0433) $display("FAIL wait_done_instr got=%0h exp=433", if_id_instr); else chk_pass++;
        chk_total++; if (if_id_valid !== 1'b1) $display("FAIL wait_done_valid got=%0h exp=1", if_id_valid); else chk_pass++;
        chk_total++; if (fetch_count !== 32'd3) $display("FAIL wait_done_count got=%0d exp=3", fetch_count); else chk_pass++;
        chk_total++; if (dut.state_q !== RUN) $display("FAIL wait_done_state got=%0d exp=%0d", dut.state_q, RUN); else chk_pass++;
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk_total++; if (imem_addr !== 64'd12) $display("FAIL stall%0d_pc got=%0h exp=c", i, imem_addr); else chk_pass++;
            chk_total++; if (if_id_pc !== 64'd8) $display("FAIL stall%0d_ifid_pc got=%0h exp=8", i, if_id_pc); else chk_pass++;
            chk_total++; if (if_id_instr !== 32'h0000_0433) $display("FAIL stall%0d_instr got=%0h exp=433", i, if_id_instr); else chk_pass++;
            chk_total++; if (if_id_valid !== 1'b1) $display("FAIL stall%0d_valid got=%0h exp=1", i, if_id_valid); else chk_pass++;
            chk_total++; if (fetch_count !== 32'd3) $display("FAIL stall%0d_count got=%0d exp=3", i, fetch_count); else chk_pass++;
        end
        stall = 1'b0;
        step();
        chk_total++; if (if_id_pc !== 64'd12) $display("FAIL unstall_pc got=%0h exp=c", if_id_pc); else chk_pass++;
        chk_total++; if (if_id_instr !== 32'h0000_0633) $display("FAIL unstall_instr got=%0h exp=633", if_id_instr); else chk_pass++;
        chk_total++; if (fetch_count !== 32'd4) $display("FAIL unstall_count got=%0d exp=4", fetch_count); else chk_pass++;
        chk_total++; if (imem_addr !== 64'd16) $display("FAIL unstall_next_pc got=%0h exp=10", imem_addr); else chk_pass++;
    endtask

    task automatic test_branch_priority();
        branch_taken = 1'b1; stall = 1'b1; branch_target = 64'h103;
        step();
        chk_total++; if (imem_addr !== 64'h100) $display("FAIL br_pc got=%0h exp=100", imem_addr); else chk_pass++;
        chk_total++; if (if_id_valid !== 1'b0) $display("FAIL br_valid got=%0h exp=0", if_id_valid); else chk_pass++;
        chk_total++; if (if_id_instr !== 32'h0000_0013) $display("FAIL br_instr got=%0h exp=13", if_id_instr); else chk_pass++;
        chk_total++; if (if_id_pc !== 64'd12) $display("FAIL br_ifid_pc got=%0h exp=c", if_id_pc); else chk_pass++;
        chk_total++; if (fetch_count !== 32'd4) $display("FAIL br_count got=%0d exp=4", fetch_count); else chk_pass++;
        branch_taken = 1'b0; stall = 1'b0;
        step();
        chk_total++; if (if_id_pc !== 64'h100) $display("FAIL br_tgt_pc got=%0h exp=100", if_id_pc); else chk_pass++;
        chk_total++; if (if_id_instr !== 32'h0000_8033) $display("FAIL br_tgt_instr got=%0h exp=8033", if_id_instr); else chk_pass++;
        chk_total++; if (fetch_count !== 32'd5) $display("FAIL br_tgt_count got=%0d exp=5", fetch_count); else chk_pass++;
    endtask

    task automatic test_pc_wrap();
        branch_taken = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        branch_taken = 1'b0;
        chk_total++; if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) $display("FAIL wrap_pc got=%0h exp=fffffffffffffffc", imem_addr); else chk_pass++;
        step();
        chk_total++; if (imem_addr !== 64'd0) $display("FAIL wrap_next_pc got=%0h exp=0", imem_addr); else chk_pass++;
        chk_total++; if (if_id_pc !== 64'hFFFF_FFFF_FFFF_FFFC) $display("FAIL wrap_ifid_pc got=%0h exp=fffffffffffffffc", if_id_pc); else chk_pass++;
        chk_total++; if (if_id_instr !== 32'hFFFF_FE33) $display("FAIL wrap_instr got=%0h exp=fffffe33", if_id_instr); else chk_pass++;
        chk_total++; if (fetch_count !== 32'd6) $display("FAIL wrap_count got=%0d exp=6", fetch_count); else chk_pass++;
    endtask

    task automatic test_reset_in_wait();
        imem_ready = 1'b0;
        step();
        chk_total++; if (dut.state_q !== WAIT) $display("FAIL rw_state got=%0d exp=%0d", dut.state_q, WAIT); else chk_pass++;
        reset = 1'b1; branch_taken = 1'b1; stall = 1'b1; branch_target = 64'h200;
        step();
        chk_total++; if (imem_addr !== 64'd0) $display("FAIL rw_pc got=%0h exp=0", imem_addr); else chk_pass++;
        chk_total++; if (imem_req !== 1'b0) $display("FAIL rw_req got=%0h exp=0", imem_req); else chk_pass++;
        chk_total++; if (dut.state_q !== IDLE) $display("FAIL rw_state_idle got=%0d exp=%0d", dut.state_q, IDLE); else chk_pass++;
        chk_total++; if (fetch_count !== 32'd0) $display("FAIL rw_count got=%0d exp=0", fetch_count); else chk_pass++;
        chk_total++; if (if_id_pc !== 64'd0) $display("FAIL rw_ifid_pc got=%0h exp=0", if_id_pc); else chk_pass++;
        chk_total++; if (if_id_valid !== 1'b0) $display("FAIL rw_valid got=%0h exp=0", if_id_valid); else chk_pass++;
        reset = 1'b0; branch_taken = 1'b0; stall = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_back_to_back();
        test_wait_states();
        test_stall();
        test_branch_priority();
        test_pc_wrap();
        test_reset_in_wait();
        $display("%0d/%0d checks passed", chk_pass, chk_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001: Ports SHALL be clk, reset, stall, branch_taken, branch_target, imem_req, imem_addr, imem_rdata, imem_ready, if_id_pc, if_id_instr, if_id_opcode, if_id_valid, fetch_count.
REQ-002: One clock, clk; reset is synchronous and active-high.
REQ-003: clk  input  1  rising-edge clock for all state.
REQ-004: reset  input  1  synchronous active-high reset.
REQ-005: stall  input  1  hazard unit hold request; freezes PC and IF/ID.
REQ-006: branch_taken  input  1  redirect request from branch resolution.
REQ-007: branch_target  input  64  redirect byte address.
REQ-008: imem_req  output  1  instruction memory read request.
REQ-009: imem_addr  output  64  word-aligned fetch address, equal to the current PC.
REQ-010: imem_rdata  input  32  instruction word for imem_addr; valid when imem_ready=1.
REQ-011: imem_ready  input  1  same-cycle read-data valid; low inserts wait states.
REQ-012: if_id_pc  output  64  PC of the registered instruction.
REQ-013: if_id_instr  output  32  registered instruction word.
REQ-014: if_id_opcode  output  7  if_id_instr[6:0], driven to the decoder.
REQ-015: if_id_valid  output  1  1 = real instruction; 0 = bubble.
REQ-016: fetch_count  output  32  number of instructions delivered to IF/ID since reset.

Function
REQ-017: FSM states SHALL be IDLE, RUN, WAIT; IDLE->RUN unconditionally after one cycle; RUN->WAIT when imem_req=1 and imem_ready=0 and no branch_taken; WAIT->RUN when imem_ready=1 or branch_taken=1.
REQ-018: imem_req SHALL be 0 in IDLE and 1 in RUN and WAIT; imem_addr SHALL always equal PC.
REQ-019: Update priority at each edge SHALL be: branch_taken > stall > imem_ready.
REQ-020: branch_taken=1 -> PC <= {branch_target[63:2],2'b00}; IF/ID <= bubble; fetch_count held.
REQ-021: Else stall=1 -> PC, IF/ID, fetch_count held; instruction returned that cycle is discarded and refetched later.
REQ-022: Else imem_req=1 and imem_ready=1 -> IF/ID <= {PC, imem_rdata, valid=1}; PC <= PC+4; fetch_count +1.
REQ-023: Else (IDLE or ready low) -> PC held; IF/ID <= bubble.
REQ-024: Bubble SHALL be if_id_instr=32'h00000013 (addi x0,x0,0), if_id_opcode=7'b0010011, if_id_valid=0, if_id_pc held.
REQ-025: PC+4 and fetch_count+1 SHALL wrap modulo 2^64 and 2^32 respectively, with no flag.
REQ-026: Fetch-to-IF/ID latency SHALL be one clock with zero wait states, giving throughput of one instruction per cycle.

Reset
REQ-027: reset=1 at an edge SHALL force state=IDLE, PC=0, fetch_count=0, and IF/ID=bubble with if_id_pc=0.
REQ-028: Reset SHALL override branch_taken and stall, including a reset asserted mid-WAIT.

Structure
REQ-029: Shared package SHALL hold the NOP constant 32'h00000013, the opcode constants (0110011, 0000011, 0100011, 1100011, 0010011), and the IDLE/RUN/WAIT state encoding.
REQ-030: The IF/ID register with hold/bubble controls SHALL be a sub-module named if_id_register; the PC, FSM and counter SHALL stay at top level.

Verification
REQ-031: Reset, then imem_ready=1 with the memory returning 32'h00A00093 at address 0 -> IDLE one cycle, then if_id_pc=0, if_id_instr=00A00093, if_id_opcode=0010011, valid=1, PC=4.
REQ-032: imem_ready held low 3 cycles at PC=8 -> 3 bubbles, state WAIT, PC stays 8; ready high -> instruction at 8 delivered, fetch_count +1.
REQ-033: stall=1 for 2 cycles at PC=12 -> PC and IF/ID unchanged, fetch_count unchanged; release -> fetch resumes at 12.
REQ-034: branch_taken=1, stall=1, branch_target=0x103 at the same edge -> PC=0x100, IF/ID bubble, valid=0.
REQ-035: PC=0xFFFF_FFFF_FFFF_FFFC with ready=1 -> next PC=0; reset asserted during WAIT -> PC=0, state IDLE, fetch_count=0.
